dmp_csr_regs: RTL and testbench



---
 rtl/dmp_csr_regs.sv | 206 ++++++++++++++++++++
 tb/tb_dmp_csr_regs.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmp_csr_regs.sv
// rtl/dmp_csr_regs.sv - PMP/JITDomain CSR banks, WARL/lock rules and domain-switch sequencer
//
// Holds pmpcfg, pmpaddr and dmpcfg banks plus the current domain, and sequences
// domain switches through an LSU drain and a frontend flush handshake.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   csr_we_i/sel_i/idx_i/wdata_i    register write (sel 00 pmpcfg, 01 pmpaddr, 10 dmpcfg)
//   csr_ready_o                     write accepted this cycle (IDLE only)
//   csr_rsel_i/ridx_i, csr_rdata_o  combinational readback, zero-extended
//   dom_req_i/target_i              domain-switch request
//   dom_gnt_o/done_o/err_o          accept pulse, finish pulse, timeout-abort pulse
//   lsu_idle_i                      LSU has nothing outstanding
//   flush_o/flush_ack_i             frontend/TLB flush handshake
//   conf_addr_o, pmpconf_o,
//   dmpconf_o, curdom_o             registered state for the PMP checkers
//
// Build option: DMP_SWITCH_DRAIN_EN adds the DRAIN state, its timeout counter
// and dom_err_o; without it IDLE goes straight to SWITCH and lsu_idle_i is unused.
//
// pmpcfg byte: [7] L, [6:5] reserved, [4:3] A, [2] R, [1] W, [0] X.
// dmpcfg byte: [7] L, [6:4] reserved, [3:0] domain.

module dmp_csr_regs #(
    parameter int PMP_LEN       = 54,
    parameter int NR_ENTRIES    = 16,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      csr_we_i,
    input  logic [1:0]                csr_sel_i,
    input  logic [3:0]                csr_idx_i,
    input  logic [PMP_LEN-1:0]        csr_wdata_i,
    output logic                      csr_ready_o,
    input  logic [1:0]                csr_rsel_i,
    input  logic [3:0]                csr_ridx_i,
    output logic [PMP_LEN-1:0]        csr_rdata_o,
    input  logic                      dom_req_i,
    input  logic [3:0]                dom_target_i,
    output logic                      dom_gnt_o,
    output logic                      dom_done_o,
    output logic                      dom_err_o,
    input  logic                      lsu_idle_i,
    output logic                      flush_o,
    input  logic                      flush_ack_i,
    output logic [15:0][PMP_LEN-1:0]  conf_addr_o,
    output logic [15:0][7:0]          pmpconf_o,
    output logic [15:0][7:0]          dmpconf_o,
    output logic [3:0]                curdom_o
);

    localparam logic [1:0] A_TOR = 2'b01;
    localparam logic [3:0] DOMI  = 4'h0;

    typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, FLUSH} state_t;

    state_t      state, state_next;
    logic        wr;
    logic [15:0] cfg_wr, addr_wr, dmp_wr;
    logic [16:0][7:0] cfg_ext;
    logic [7:0]  cfg_wdata, dmp_wdata;
    logic [3:0]  target;
    logic        done_q, done_set;

    assign wr = csr_we_i && csr_ready_o;

    // Per-entry write enables. Entries at or above NR_ENTRIES never get one, so
    // their registers stay at reset value and read back / drive zero.
    // cfg_ext pads a 17th zero entry so entry i can look at entry i+1 for TOR.
    always_comb begin
        cfg_wr  = '0;
        addr_wr = '0;
        dmp_wr  = '0;
        cfg_ext = {8'h00, pmpconf_o};
        for (int i = 0; i < 16; i++) begin
            if (wr && i < NR_ENTRIES && csr_idx_i == 4'(i)) begin
                cfg_wr[i]  = (csr_sel_i == 2'b00) && !pmpconf_o[i][7];
                addr_wr[i] = (csr_sel_i == 2'b01) && !pmpconf_o[i][7] &&
                             !((i + 1 < NR_ENTRIES) && cfg_ext[i+1][7] &&
                               cfg_ext[i+1][4:3] == A_TOR);
                dmp_wr[i]  = (csr_sel_i == 2'b10) && !dmpconf_o[i][7];
            end
        end
    end

    // WARL: reserved bits read 0; write-only (W=1, R=0) is stored as W=0.
    always_comb begin
        cfg_wdata = csr_wdata_i[7:0] & 8'h9F;
        if (cfg_wdata[1] && !cfg_wdata[2]) begin
            cfg_wdata[1] = 1'b0;
        end
        dmp_wdata = csr_wdata_i[7:0] & 8'h8F;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pmpconf_o   <= '0;
            conf_addr_o <= '0;
            dmpconf_o   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (cfg_wr[i])  pmpconf_o[i]   <= cfg_wdata;
                if (addr_wr[i]) conf_addr_o[i] <= csr_wdata_i;
                if (dmp_wr[i])  dmpconf_o[i]   <= dmp_wdata;
            end
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_rsel_i)
            2'b00:   csr_rdata_o = PMP_LEN'(pmpconf_o[csr_ridx_i]);
            2'b01:   csr_rdata_o = conf_addr_o[csr_ridx_i];
            2'b10:   csr_rdata_o = PMP_LEN'(dmpconf_o[csr_ridx_i]);
            default: csr_rdata_o = '0;
        endcase
    end

`ifdef DMP_SWITCH_DRAIN_EN
    logic [7:0] drain_cnt;
    logic       cnt_clr, cnt_inc, err_q, err_set;
    assign dom_err_o = err_q;
`else
    logic unused_lsu_idle;
    assign unused_lsu_idle = lsu_idle_i;
    assign dom_err_o       = 1'b0;
`endif

    assign dom_done_o = done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            target   <= DOMI;
            curdom_o <= DOMI;
            done_q   <= 1'b0;
`ifdef DMP_SWITCH_DRAIN_EN
            err_q     <= 1'b0;
            drain_cnt <= '0;
`endif
        end else begin
            state  <= state_next;
            done_q <= done_set;
            if (dom_gnt_o) target <= dom_target_i;
            if (state == SWITCH) curdom_o <= target;
`ifdef DMP_SWITCH_DRAIN_EN
            err_q <= err_set;
            if (cnt_clr)      drain_cnt <= '0;
            else if (cnt_inc) drain_cnt <= drain_cnt + 8'd1;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        csr_ready_o = 1'b0;
        dom_gnt_o   = 1'b0;
        flush_o     = 1'b0;
        done_set    = 1'b0;
`ifdef DMP_SWITCH_DRAIN_EN
        err_set = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
`endif
        case (state)
            IDLE: begin
                csr_ready_o = 1'b1;
                if (dom_req_i) begin
                    dom_gnt_o = 1'b1;
`ifdef DMP_SWITCH_DRAIN_EN
                    cnt_clr    = 1'b1;
                    state_next = DRAIN;
`else
                    state_next = SWITCH;
`endif
                end
            end
`ifdef DMP_SWITCH_DRAIN_EN
            // An idle LSU wins over the timeout in the same cycle; the abort
            // fires in the DRAIN cycle that sees the counter at DRAIN_TIMEOUT.
            DRAIN: begin
                if (lsu_idle_i) begin
                    state_next = SWITCH;
                end else if (drain_cnt == 8'(DRAIN_TIMEOUT)) begin
                    done_set   = 1'b1;
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`endif
            SWITCH: state_next = FLUSH;
            FLUSH: begin
                flush_o = 1'b1;
                if (flush_ack_i) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmp_csr_regs.sv
// tb/tb_dmp_csr_regs.sv - self-checking bench for dmp_csr_regs

module tb_dmp_csr_regs;

    localparam int PL = 54;
    localparam int NR = 8;
    localparam int TO = 4;
`ifdef DMP_SWITCH_DRAIN_EN
    localparam bit HAS_DRAIN = 1'b1;
`else
    localparam bit HAS_DRAIN = 1'b0;
`endif

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                 rst_i = 1'b1;
    logic                 csr_we_i = 1'b0;
    logic [1:0]           csr_sel_i = '0;
    logic [3:0]           csr_idx_i = '0;
    logic [PL-1:0]        csr_wdata_i = '0;
    logic                 csr_ready_o;
    logic [1:0]           csr_rsel_i = '0;
    logic [3:0]           csr_ridx_i = '0;
    logic [PL-1:0]        csr_rdata_o;
    logic                 dom_req_i = 1'b0;
    logic [3:0]           dom_target_i = '0;
    logic                 dom_gnt_o, dom_done_o, dom_err_o;
    logic                 lsu_idle_i = 1'b1;
    logic                 flush_o;
    logic                 flush_ack_i = 1'b0;
    logic [15:0][PL-1:0]  conf_addr_o;
    logic [15:0][7:0]     pmpconf_o;
    logic [15:0][7:0]     dmpconf_o;
    logic [3:0]           curdom_o;

    dmp_csr_regs #(.PMP_LEN(PL), .NR_ENTRIES(NR), .DRAIN_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .csr_we_i(csr_we_i), .csr_sel_i(csr_sel_i), .csr_idx_i(csr_idx_i),
        .csr_wdata_i(csr_wdata_i), .csr_ready_o(csr_ready_o),
        .csr_rsel_i(csr_rsel_i), .csr_ridx_i(csr_ridx_i), .csr_rdata_o(csr_rdata_o),
        .dom_req_i(dom_req_i), .dom_target_i(dom_target_i),
        .dom_gnt_o(dom_gnt_o), .dom_done_o(dom_done_o), .dom_err_o(dom_err_o),
        .lsu_idle_i(lsu_idle_i), .flush_o(flush_o), .flush_ack_i(flush_ack_i),
        .conf_addr_o(conf_addr_o), .pmpconf_o(pmpconf_o), .dmpconf_o(dmpconf_o),
        .curdom_o(curdom_o)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Architectural model
    logic [7:0]    m_pcfg [16];
    logic [PL-1:0] m_paddr[16];
    logic [7:0]    m_dcfg [16];
    logic [3:0]    m_curdom;

    // Current switch described as a timeline relative to the grant cycle
    bit         sw_active = 1'b0;
    int         sw_t0 = -1000;
    int         sw_n, sw_k;
    bit         sw_to;
    logic [3:0] sw_target;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pre_len();
        return HAS_DRAIN ? 1 + sw_n : 0;
    endfunction

    function automatic int done_rel();
        return sw_to ? 2 + TO : 3 + pre_len() + sw_k;
    endfunction

    function automatic bit m_ready();
        int rel = cyc - sw_t0;
        return !(sw_active && rel >= 1 && rel < done_rel());
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_pcfg[i]  = '0;
            m_paddr[i] = '0;
            m_dcfg[i]  = '0;
        end
        m_curdom  = 4'h0;
        sw_active = 1'b0;
    endfunction

    function automatic void apply_write(input logic [1:0] sel, input logic [3:0] idx, input logic [PL-1:0] d);
        logic [7:0] v;
        bit lk;
        if (sel == 2'b11 || int'(idx) >= NR) return;
        case (sel)
            2'b00: if (!m_pcfg[idx][7]) begin
                v = d[7:0];
                v[6:5] = 2'b00;
                if (v[1] && !v[2]) v[1] = 1'b0;
                m_pcfg[idx] = v;
            end
            2'b01: begin
                lk = m_pcfg[idx][7];
                if (int'(idx) + 1 < NR && m_pcfg[idx+1][7] && m_pcfg[idx+1][4:3] == 2'b01) lk = 1'b1;
                if (!lk) m_paddr[idx] = d;
            end
            2'b10: if (!m_dcfg[idx][7]) begin
                v = d[7:0];
                v[6:4] = 3'b000;
                m_dcfg[idx] = v;
            end
            default: ;
        endcase
    endfunction

    // Cycle counter and readback address sweep (all banks, all indices)
    always @(posedge clk_i) begin
        cyc = cyc + 1;
        #1;
        csr_rsel_i = 2'(cyc % 4);
        csr_ridx_i = 4'((cyc / 4) % 16);
    end

    // Compare process
    always @(negedge clk_i) begin
        int rel;
        logic e_gnt, e_done, e_err, e_flush, e_ready;
        logic [3:0] e_cd;
        logic [15:0][7:0] ec, ed;
        logic [15:0][PL-1:0] ea;
        logic [PL-1:0] er;
        if (chk_en) begin
            rel = cyc - sw_t0;
            e_gnt = 0; e_done = 0; e_err = 0; e_flush = 0; e_ready = 1; e_cd = m_curdom;
            if (sw_active) begin
                e_gnt   = (rel == 0);
                e_done  = (rel == done_rel());
                e_err   = sw_to && e_done;
                e_flush = !sw_to && rel >= 2 + pre_len() && rel <= 2 + pre_len() + sw_k;
                e_ready = m_ready();
                if (!sw_to && rel >= 2 + pre_len()) e_cd = sw_target;
            end
            for (int i = 0; i < 16; i++) begin
                ec[i] = m_pcfg[i];
                ed[i] = m_dcfg[i];
                ea[i] = m_paddr[i];
            end
            case (csr_rsel_i)
                2'b00:   er = PL'(m_pcfg[csr_ridx_i]);
                2'b01:   er = m_paddr[csr_ridx_i];
                2'b10:   er = PL'(m_dcfg[csr_ridx_i]);
                default: er = '0;
            endcase
            chk("csr_ready", csr_ready_o, e_ready);
            chk("dom_gnt", dom_gnt_o, e_gnt);
            chk("dom_done", dom_done_o, e_done);
            chk("dom_err", dom_err_o, e_err);
            chk("flush", flush_o, e_flush);
            chk("curdom", curdom_o, e_cd);
            chk("pmpconf", pmpconf_o, ec);
            chk("conf_addr", conf_addr_o, ea);
            chk("dmpconf", dmpconf_o, ed);
            chk("csr_rdata", csr_rdata_o, er);
        end
    end

    task automatic csr_write(input logic [1:0] sel, input logic [3:0] idx, input logic [PL-1:0] data);
        bit acc;
        bit done = 1'b0;
        csr_we_i = 1'b1; csr_sel_i = sel; csr_idx_i = idx; csr_wdata_i = data;
        for (int g = 0; g < 64 && !done; g++) begin
            acc = m_ready();
            @(posedge clk_i); #1;
            if (acc) begin
                apply_write(sel, idx, data);
                done = 1'b1;
            end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL csr_write_bound: got stalled expected accepted (cycle %0d)", cyc);
        end
        csr_we_i = 1'b0;
    endtask

    // n: DRAIN cycles with lsu_idle low; k: extra FLUSH cycles before ack;
    // to: hold lsu_idle low until timeout; extra: second request in cycle 1;
    // rst_rel: relative cycle at which reset is asserted (-1 for none).
    task automatic do_switch(input logic [3:0] tgt, input int n, input int k, input bit to,
                             input bit extra, input int rst_rel);
        int dr;
        sw_t0 = cyc; sw_n = n; sw_k = k; sw_to = to; sw_target = tgt; sw_active = 1'b1;
        dr = done_rel();
        for (int rel = 0; rel <= dr; rel++) begin
            dom_req_i    = (rel == 0) || (extra && rel == 1);
            dom_target_i = (rel == 0) ? tgt : ~tgt;
            lsu_idle_i   = !to && rel >= 1 + n;
            flush_ack_i  = rel >= 2 + pre_len() + k;
            if (rel == rst_rel) rst_i = 1'b1;
            @(posedge clk_i); #1;
            if (rel == rst_rel) begin
                rst_i = 1'b0;
                model_reset();
                dom_req_i = 1'b0; flush_ack_i = 1'b0; lsu_idle_i = 1'b1;
                return;
            end
        end
        dom_req_i = 1'b0; flush_ack_i = 1'b0; lsu_idle_i = 1'b1;
        if (!to) m_curdom = tgt;
        sw_active = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk_en = 1'b1;
        @(negedge clk_i);
        chk("rst_ready_lit", csr_ready_o, 1'b1);
        chk("rst_curdom_lit", curdom_o, 4'h0);
        chk("rst_pmpconf_lit", pmpconf_o, 128'h0);
        @(posedge clk_i); #1;

        csr_write(2'b00, 4'd2, 54'h0B);
        chk("pcfg2_wclr_lit", pmpconf_o[2], 8'h09);
        csr_write(2'b00, 4'd5, 54'h6F);
        chk("pcfg5_resv_lit", pmpconf_o[5], 8'h0F);
        csr_write(2'b00, 4'd6, 54'h02);
        csr_write(2'b00, 4'd1, 54'h07);
        csr_write(2'b01, 4'd1, 54'h0ABC);
        chk("paddr1_tor_unlocked_lit", conf_addr_o[1], 54'h0ABC);

        csr_write(2'b00, 4'd3, 54'h88);
        csr_write(2'b01, 4'd2, 54'h1000);
        csr_write(2'b01, 4'd3, 54'h2000);
        csr_write(2'b00, 4'd3, 54'h00);
        chk("paddr2_tor_lock_lit", conf_addr_o[2], 54'h0);
        chk("pcfg3_lock_lit", pmpconf_o[3], 8'h88);
        csr_write(2'b01, 4'd4, 54'h3F_FFFF_FFFF_FFFF);
        csr_write(2'b00, 4'd7, 54'h80);
        csr_write(2'b01, 4'd6, 54'h1234);
        csr_write(2'b01, 4'd7, 54'h5678);
        chk("paddr7_lock_lit", conf_addr_o[7], 54'h0);

        csr_write(2'b10, 4'd0, 54'h85);
        csr_write(2'b10, 4'd0, 54'h03);
        chk("dcfg0_lock_lit", dmpconf_o[0], 8'h85);
        csr_write(2'b10, 4'd1, 54'h7A);
        csr_write(2'b00, 4'd14, 54'h01);
        chk("pcfg14_unimpl_lit", pmpconf_o[14], 8'h00);
        csr_write(2'b11, 4'd2, 54'hFF);

        do_switch(4'h5, 0, 0, 1'b0, 1'b0, -1);
        chk("switch5_curdom_lit", curdom_o, 4'h5);
        do_switch(4'h9, 2, 2, 1'b0, 1'b1, -1);
        fork
            do_switch(4'h3, 0, 0, 1'b0, 1'b0, -1);
            csr_write(2'b00, 4'd4, 54'h05);
        join
        fork
            do_switch(4'h6, 1, 1, 1'b0, 1'b0, -1);
            begin
                @(posedge clk_i); #1;
                csr_write(2'b10, 4'd2, 54'h0C);
            end
        join
        chk("stalled_write_lit", dmpconf_o[2], 8'h0C);
`ifdef DMP_SWITCH_DRAIN_EN
        do_switch(4'hA, 0, 0, 1'b1, 1'b0, -1);
        chk("timeout_curdom_lit", curdom_o, 4'h6);
        do_switch(4'h7, TO, 0, 1'b0, 1'b0, -1);
        chk("drain_edge_curdom_lit", curdom_o, 4'h7);
`endif
        do_switch(4'hC, 0, 10, 1'b0, 1'b0, HAS_DRAIN ? 4 : 3);
        chk("rst_flush_lit", flush_o, 1'b0);
        chk("rst_curdom2_lit", curdom_o, 4'h0);
        chk("rst_pcfg3_lit", pmpconf_o[3], 8'h00);
        csr_write(2'b10, 4'd0, 54'h03);
        chk("dcfg0_after_rst_lit", dmpconf_o[0], 8'h03);

        repeat (4) @(posedge clk_i);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
